// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// fetched from an external combinational table through keyIdx.
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start latches
// word and occupies INIT + 10 ROUND cycles. done is a one-cycle registered pulse
// and str holds the plaintext from that cycle until the next completion.
module inv_cipher_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] word,
    output logic [3:0]   keyIdx,
    input  logic [127:0] key,
    output logic [7:0]   count,
    output logic         busy,
    output logic         done,
    output logic [127:0] str,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} state_t;

    state_t       state_q;
    logic [127:0] st_q;
    logic [127:0] str_q;
    logic [3:0]   key_idx_q;
    logic [7:0]   count_q;
    logic         busy_q;
    logic         done_q;
    logic [127:0] last_d;
    logic [127:0] round_d;

    // GF(2^8) multiply, reduction polynomial 0x11b
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8)
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // InvShiftRows followed by InvSubBytes; byte n sits at row n%4, col n/4
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((c + 4 - r) % 4) + r;
                o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * src -: 8]);
            end
        end
        return o;
    endfunction

    // InvMixColumns with coefficients {0e,0b,0d,09}
    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Round datapath: last round skips InvMixColumns
    always_comb begin
        last_d  = inv_shift_sub(st_q) ^ key;
        round_d = inv_mix(last_d);
    end

    // Control FSM and state register; done/str are set on the edge entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            st_q      <= '0;
            str_q     <= '0;
            key_idx_q <= 4'd0;
            count_q   <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        st_q      <= word;
                        key_idx_q <= 4'd10;
                        count_q   <= 8'd10;
                        busy_q    <= 1'b1;
                        state_q   <= S_INIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_INIT: begin
                    st_q      <= st_q ^ key;
                    key_idx_q <= 4'd9;
                    count_q   <= 8'd9;
                    state_q   <= S_ROUND;
                end
                S_ROUND: begin
                    if (count_q == 8'd0) begin
                        st_q    <= last_d;
                        str_q   <= last_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        st_q      <= round_d;
                        key_idx_q <= key_idx_q - 4'd1;
                        count_q   <= count_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign keyIdx      = key_idx_q;
    assign count       = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign str         = str_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: round-key table built by a key-expansion model,
// random blocks produced by a forward AES model, results checked through a
// scoreboard queue of expected plaintexts.
module tb_inv_cipher_iter;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] word;
    logic [3:0]   keyIdx;
    logic [127:0] key;
    logic [7:0]   count;
    logic         busy;
    logic         done;
    logic [127:0] str;
    logic [1:0]   dbg_state_o;

    logic [127:0] rk [0:10];
    logic [127:0] exp_q [$];
    int           n_checks;
    int           n_errors;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] IST_C1 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    inv_cipher_iter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .word        (word),
        .keyIdx      (keyIdx),
        .key         (key),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .str         (str),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Combinational round-key table
    assign key = (keyIdx <= 4'd10) ? rk[keyIdx] : 128'h0;

    // ---------------- reference models ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            p = xt(p);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (m_mul(a, y[7:0]) == 8'h01) r = y[7:0];
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = m_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Forward AES-128 using the current rk table
    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        s = pt ^ rk[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            t = '0;
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    src = 4 * ((c + r) % 4) + r;
                    t[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * src -: 8]);
                end
            end
            if (rnd != 10) begin
                m = '0;
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127 - 32 * c -: 8];
                    a1 = t[119 - 32 * c -: 8];
                    a2 = t[111 - 32 * c -: 8];
                    a3 = t[103 - 32 * c -: 8];
                    m[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    m[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    m[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    m[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
                t = m;
            end
            s = t ^ rk[rnd];
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_done: str=%h with no expected result queued", str);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (str !== e) begin
                    n_errors++;
                    $display("FAIL sb_str: got %h expected %h", str, e);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        word  = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({keyIdx, count, busy, done, str, dbg_state_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: keyIdx=%0d count=%0d busy=%b done=%b str=%h st=%0d, required all 0",
                     keyIdx, count, busy, done, str, dbg_state_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // FIPS-197 C.1 with full round trace and istart check
    task automatic test_fips_c1();
        expand_key(KEY_C1);
        @(negedge clk);
        start = 1'b1;
        word  = CT_C1;
        exp_q.push_back(PT_C1);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k <= 11) begin
                n_checks++;
                if (keyIdx !== 4'(11 - k) || count !== 8'(11 - k) || busy !== 1'b1 || done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL c1_trace k=%0d: keyIdx=%0d count=%0d busy=%b done=%b, required %0d %0d 1 0",
                             k, keyIdx, count, busy, done, 11 - k, 11 - k);
                end
            end
            if (k == 2) begin
                n_checks++;
                if (dut.st_q !== IST_C1) begin
                    n_errors++;
                    $display("FAIL c1_istart: st=%h expected %h", dut.st_q, IST_C1);
                end
            end
            if (k == 12) begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0 || str !== PT_C1) begin
                    n_errors++;
                    $display("FAIL c1_done: done=%b busy=%b str=%h, required 1 0 %h", done, busy, str, PT_C1);
                end
            end
            if (k == 13) begin
                n_checks++;
                if (done !== 1'b0 || str !== PT_C1 || keyIdx !== 4'd0) begin
                    n_errors++;
                    $display("FAIL c1_after: done=%b str=%h keyIdx=%0d, required 0 %h 0", done, str, keyIdx, PT_C1);
                end
            end
        end
    endtask

    // start held high for three blocks; done only at T+12/24/36
    task automatic test_back_to_back();
        logic [127:0] pt [0:2];
        logic [127:0] ct [0:2];
        logic         exp_done;
        for (int i = 0; i < 3; i++) begin
            pt[i] = rand128();
            ct[i] = aes_enc(pt[i]);
            exp_q.push_back(pt[i]);
        end
        @(negedge clk);
        start = 1'b1;
        word  = ct[0];
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            if (k == 1)  word  = ct[1];
            if (k == 13) word  = ct[2];
            if (k == 25) start = 1'b0;
            exp_done = (k % 12 == 0) && (k <= 36);
            n_checks++;
            if (done !== exp_done || busy !== (k <= 36 && !exp_done)) begin
                n_errors++;
                $display("FAIL b2b_timing k=%0d: done=%b busy=%b, required %b %b",
                         k, done, busy, exp_done, (k <= 36 && !exp_done));
            end
        end
    endtask

    // start with word=0 while busy must not disturb the running block
    task automatic test_ignore_start();
        logic [127:0] pt;
        int           n_done;
        pt = rand128();
        @(negedge clk);
        start = 1'b1;
        word  = aes_enc(pt);
        exp_q.push_back(pt);
        n_done = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin
                start = 1'b1;
                word  = '0;
            end
            if (k == 6) start = 1'b0;
            if (done === 1'b1) n_done++;
            if (k == 12) begin
                n_checks++;
                if (done !== 1'b1 || str !== pt) begin
                    n_errors++;
                    $display("FAIL ignore_result: done=%b str=%h, required 1 %h", done, str, pt);
                end
            end
        end
        n_checks++;
        if (n_done !== 1) begin
            n_errors++;
            $display("FAIL ignore_done_count: got %0d pulses, required 1", n_done);
        end
    endtask

    // reset at T+6 aborts; then a fresh block decrypts correctly
    task automatic test_reset_abort();
        logic [127:0] pt;
        int           n_done;
        pt = rand128();
        @(negedge clk);
        start = 1'b1;
        word  = aes_enc(pt);
        exp_q.push_back(pt);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 5) begin
                rst = 1'b1;
                exp_q.delete();
            end
            if (k == 6) begin
                rst = 1'b0;
                n_checks++;
                if ({keyIdx, count, busy, done, str, dbg_state_o} !== '0) begin
                    n_errors++;
                    $display("FAIL abort_outputs: keyIdx=%0d count=%0d busy=%b done=%b str=%h st=%0d, required all 0",
                             keyIdx, count, busy, done, str, dbg_state_o);
                end
            end
        end
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_errors++;
            $display("FAIL abort_no_done: got %0d pulses, required 0", n_done);
        end
        pt = rand128();
        @(negedge clk);
        start = 1'b1;
        word  = aes_enc(pt);
        exp_q.push_back(pt);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        n_checks++;
        if (done !== 1'b1 || str !== pt) begin
            n_errors++;
            $display("FAIL abort_restart: done=%b str=%h, required 1 %h", done, str, pt);
        end
    endtask

    // All-zero key known-answer vector
    task automatic test_zero_key();
        expand_key('0);
        @(negedge clk);
        start = 1'b1;
        word  = CT_Z;
        exp_q.push_back('0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        n_checks++;
        if (done !== 1'b1 || str !== 128'h0) begin
            n_errors++;
            $display("FAIL zero_key: done=%b str=%h, required 1 0", done, str);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int r = 0; r <= 10; r++) rk[r] = '0;
        test_reset();
        test_fips_c1();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_zero_key();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: %0d expected results never produced, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
